// File: rtl/bpred_pkg.sv
// -----------------------------------------------------------------------------
// bpred_pkg
// Shared types and helpers for the branch predictor.
//   brType_t   : kind of control transfer recorded in a BTB entry
//   btbEntry_t : one BTB entry. Tag and target fields are sized for the widest
//                supported address (BP_MAX_XLEN). The predictor stores narrower
//                values zero-extended into them, and synthesis trims the
//                constant-zero bits.
//   ctrInit    : reset value of a direction counter (weakly not-taken)
// -----------------------------------------------------------------------------
package bpred_pkg;

    localparam int BP_MAX_XLEN = 32;

    typedef enum logic [1:0] {
        BR_COND = 2'd0,
        BR_JUMP = 2'd1,
        BR_CALL = 2'd2,
        BR_RET  = 2'd3
    } brType_t;

    typedef struct packed {
        logic                   valid;
        logic [BP_MAX_XLEN-1:0] tag;
        logic [BP_MAX_XLEN-1:0] target;
        brType_t                brType;
    } btbEntry_t;

    // 2^(ctrBits-1)-1: the value just below the taken threshold (0 for 1-bit counters).
    function automatic logic [3:0] ctrInit(input int ctrBits);
        logic [4:0] v;
        v = (5'd1 << (ctrBits - 1)) - 5'd1;
        return v[3:0];
    endfunction

endpackage

// File: rtl/bpred_ras.sv
// -----------------------------------------------------------------------------
// bpred_ras
// Circular return-address stack.
//   clk, rst : clock, synchronous active-high reset (empties the stack)
//   push     : write pushData as the new top
//   pop      : discard the top (no-op when empty)
//   pushData : return address to push
//   top      : current top of stack (meaningless when empty)
//   empty    : stack holds no entries
// Push and pop together replace the top; on an empty stack they act as a plain
// push. A push when full overwrites the oldest entry and the count stays at DEPTH.
// -----------------------------------------------------------------------------
module bpred_ras #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] pushData,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [W-1:0]     stack [DEPTH];
    logic [PTR_W-1:0] ptr;      // next free slot
    logic [PTR_W-1:0] topPtr;
    logic [PTR_W-1:0] nextPtr;
    logic [CNT_W-1:0] cnt;
    logic             replace;

    // Pointer arithmetic wraps explicitly, so DEPTH need not be a power of two.
    assign topPtr  = (ptr == '0)   ? LAST : ptr - 1'b1;
    assign nextPtr = (ptr == LAST) ? '0   : ptr + 1'b1;
    assign empty   = (cnt == '0);
    assign top     = stack[topPtr];
    assign replace = push && pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (replace) begin
            // Top is overwritten in place; pointer and count are unchanged.
        end else if (push) begin
            ptr <= nextPtr;
            if (cnt != FULL) cnt <= cnt + 1'b1;
        end else if (pop && !empty) begin
            ptr <= topPtr;
            cnt <= cnt - 1'b1;
        end
    end

    // Stack contents carry no reset; the count alone decides what is live.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            if (replace) stack[topPtr] <= pushData;
            else         stack[ptr]    <= pushData;
        end
    end

endmodule

// File: rtl/bpred_btb_gshare.sv
// -----------------------------------------------------------------------------
// bpred_btb_gshare
// Direct-mapped tagged BTB with saturating direction counters, optional gshare
// indexing and a return-address stack. Lookup is combinational from fetchPc;
// execute-stage updates land on the rising edge.
//   clk, rst      : clock, synchronous active-high reset
//   fetchPc       : PC being fetched
//   fetchHit      : predict taken
//   fetchTarget   : predicted next PC (0 when fetchHit=0)
//   exValid       : execute holds a live instruction; gates every update
//   exPc/exTarget : PC and resolved target of the execute instruction
//   exTaken       : resolved taken
//   exBranch      : conditional branch
//   exJump        : JAL/JALR
//   exCall/exRet  : link-register call / return hints (with exJump)
// -----------------------------------------------------------------------------
module bpred_btb_gshare
    import bpred_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int GHR_BITS  = 0,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetchPc,
    output logic            fetchHit,
    output logic [XLEN-1:0] fetchTarget,
    input  logic            exValid,
    input  logic [XLEN-1:0] exPc,
    input  logic [XLEN-1:0] exTarget,
    input  logic            exTaken,
    input  logic            exBranch,
    input  logic            exJump,
    input  logic            exCall,
    input  logic            exRet
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam int GHR_W = (GHR_BITS > 0) ? GHR_BITS : 1;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctrInit(CTR_BITS));

    function automatic logic [CTR_BITS-1:0] ctrNext(input logic [CTR_BITS-1:0] c,
                                                    input logic up);
        if (up) return (c == CTR_MAX) ? c : c + 1'b1;
        else    return (c == '0)      ? c : c - 1'b1;
    endfunction

    btbEntry_t         btb    [ENTRIES];
    logic [CTR_BITS-1:0] ctrTab [ENTRIES];
    // With GHR_BITS=0 the register is held at zero, so histIdx folds away.
    logic [GHR_W-1:0]  ghr;
    logic [IDX-1:0]    histIdx;

    logic [IDX-1:0]    fIdx;
    logic [TAG_W-1:0]  fTag;
    btbEntry_t         fEntry;
    logic              fTagHit;
    logic [CTR_BITS-1:0] fCtr;

    logic [IDX-1:0]    eIdx;
    logic [IDX-1:0]    eCtrIdx;
    logic [TAG_W-1:0]  eTag;
    brType_t           eType;
    btbEntry_t         newEntry;
    logic              btbWr;
    logic              ctrWr;

    logic              rasPush;
    logic              rasPop;
    logic              rasEmpty;
    logic [XLEN-1:0]   rasTop;
    logic              unusedPcBits;

    assign histIdx      = IDX'(ghr);
    assign unusedPcBits = ^{fetchPc[1:0], exPc[1:0]};

    // Fetch-side lookup
    assign fIdx     = fetchPc[IDX+1:2];
    assign fTag     = fetchPc[XLEN-1:IDX+2];
    assign fEntry   = btb[fIdx];
    assign fTagHit  = fEntry.valid && (fEntry.tag == BP_MAX_XLEN'(fTag));
    assign fCtr     = ctrTab[fIdx ^ histIdx];
    assign fetchHit = fTagHit && ((fEntry.brType != BR_COND) || fCtr[CTR_BITS-1]);

    always_comb begin
        fetchTarget = '0;
        if (fetchHit) begin
            if ((fEntry.brType == BR_RET) && !rasEmpty) fetchTarget = rasTop;
            else                                        fetchTarget = fEntry.target[XLEN-1:0];
        end
    end

    // Execute-side update
    assign eIdx    = exPc[IDX+1:2];
    assign eTag    = exPc[XLEN-1:IDX+2];
    assign eCtrIdx = eIdx ^ histIdx;
    assign btbWr   = exValid && (exBranch || exJump) && exTaken;
    assign ctrWr   = exValid && exBranch;
    assign rasPush = exValid && exJump && exCall;
    assign rasPop  = exValid && exJump && exRet;

    always_comb begin
        eType = BR_COND;
        if (exRet)       eType = BR_RET;
        else if (exCall) eType = BR_CALL;
        else if (exJump) eType = BR_JUMP;
    end

    always_comb begin
        newEntry        = '0;
        newEntry.valid  = 1'b1;
        newEntry.tag    = BP_MAX_XLEN'(eTag);
        newEntry.target = BP_MAX_XLEN'(exTarget);
        newEntry.brType = eType;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                ctrTab[i]    <= CTR_RST;
            end
            ghr <= '0;
        end else begin
            if (btbWr) btb[eIdx] <= newEntry;
            if (ctrWr) begin
                ctrTab[eCtrIdx] <= ctrNext(ctrTab[eCtrIdx], exTaken);
                if (GHR_BITS > 0) ghr <= GHR_W'({ghr, exTaken});
            end
        end
    end

    generate
        if (RAS_DEPTH > 0) begin : gRas
            bpred_ras #(
                .DEPTH (RAS_DEPTH),
                .W     (XLEN)
            ) uRas (
                .clk      (clk),
                .rst      (rst),
                .push     (rasPush),
                .pop      (rasPop),
                .pushData (exPc + XLEN'(4)),
                .top      (rasTop),
                .empty    (rasEmpty)
            );
        end else begin : gNoRas
            assign rasEmpty = 1'b1;
            assign rasTop   = '0;
        end
    endgenerate

endmodule

// File: tb/tb_bpred_btb_gshare.sv
// -----------------------------------------------------------------------------
// tb_bpred_btb_gshare
// Directed bench. uDutA is the default bimodal predictor; uDutG uses a 4-bit
// global history. Both see identical stimulus; expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_bpred_btb_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetchPc;
    logic        exValid;
    logic [31:0] exPc;
    logic [31:0] exTarget;
    logic        exTaken;
    logic        exBranch;
    logic        exJump;
    logic        exCall;
    logic        exRet;

    logic        hitA, hitG;
    logic [31:0] tgtA, tgtG;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpred_btb_gshare uDutA (
        .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(hitA), .fetchTarget(tgtA),
        .exValid(exValid), .exPc(exPc), .exTarget(exTarget), .exTaken(exTaken),
        .exBranch(exBranch), .exJump(exJump), .exCall(exCall), .exRet(exRet)
    );

    bpred_btb_gshare #(.GHR_BITS(4)) uDutG (
        .clk(clk), .rst(rst), .fetchPc(fetchPc), .fetchHit(hitG), .fetchTarget(tgtG),
        .exValid(exValid), .exPc(exPc), .exTarget(exTarget), .exTaken(exTaken),
        .exBranch(exBranch), .exJump(exJump), .exCall(exCall), .exRet(exRet)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        exValid  = 1'b0;
        exPc     = '0;
        exTarget = '0;
        exTaken  = 1'b0;
        exBranch = 1'b0;
        exJump   = 1'b0;
        exCall   = 1'b0;
        exRet    = 1'b0;
    endtask

    // One-cycle execute update: driven at negedge, captured at the next posedge.
    task automatic exUpd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                         input logic br, input logic jmp, input logic call, input logic ret);
        @(negedge clk);
        exValid  = 1'b1;
        exPc     = pc;
        exTarget = tgt;
        exTaken  = tk;
        exBranch = br;
        exJump   = jmp;
        exCall   = call;
        exRet    = ret;
        @(negedge clk);
        idle();
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        fetchPc = pc;
        #1;
    endtask

    logic [31:0] popExp [5];

    initial begin
        rst     = 1'b1;
        fetchPc = '0;
        idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        look(32'h100);
        chk("rstHitA", 32'(hitA), 0);
        chk("rstTgtA", tgtA, 0);
        chk("rstHitG", 32'(hitG), 0);
        chk("rstTgtG", tgtG, 0);

        // Counter training at 0x100 (starts at 1)
        exUpd(32'h100, 32'h80, 1, 1, 0, 0, 0);
        look(32'h100);
        chk("ctr2Hit", 32'(hitA), 1);
        chk("ctr2Tgt", tgtA, 32'h80);
        exUpd(32'h100, 32'h80, 1, 1, 0, 0, 0);
        look(32'h100);
        chk("ctr3Hit", 32'(hitA), 1);
        chk("ctr3Tgt", tgtA, 32'h80);
        exUpd(32'h100, 32'h80, 0, 1, 0, 0, 0);
        look(32'h100);
        chk("ctrDn2Hit", 32'(hitA), 1);
        exUpd(32'h100, 32'h80, 0, 1, 0, 0, 0);
        look(32'h100);
        chk("ctrDn1Hit", 32'(hitA), 0);
        chk("ctrDn1Tgt", tgtA, 0);

        // Unconditional jump and tag alias
        exUpd(32'h100, 32'h200, 1, 0, 1, 0, 0);
        look(32'h100);
        chk("jmpHit", 32'(hitA), 1);
        chk("jmpTgt", tgtA, 32'h200);
        look(32'h1100);
        chk("aliasHit", 32'(hitA), 0);
        chk("aliasTgt", tgtA, 0);

        // Return entry with empty RAS falls back to BTB target
        exUpd(32'h304, 32'h900, 1, 0, 1, 0, 1);
        look(32'h304);
        chk("retEmptyHit", 32'(hitA), 1);
        chk("retEmptyTgt", tgtA, 32'h900);

        // Five calls into a 4-deep stack, then pops
        for (int i = 1; i <= 5; i++) exUpd(32'(i * 16), 32'h400, 1, 0, 1, 1, 0);
        look(32'h304);
        chk("rasTop", tgtA, 32'h54);
        popExp[0] = 32'h44;
        popExp[1] = 32'h34;
        popExp[2] = 32'h24;
        popExp[3] = 32'h900;
        popExp[4] = 32'h900;
        for (int i = 0; i < 5; i++) begin
            exUpd(32'h304, 32'h900, 1, 0, 1, 0, 1);
            look(32'h304);
            chk($sformatf("rasPop%0d", i), tgtA, popExp[i]);
        end

        // Call+return together: plain push when empty, replace otherwise
        exUpd(32'h304, 32'h900, 1, 0, 1, 1, 1);
        look(32'h304);
        chk("crPush", tgtA, 32'h308);
        exUpd(32'h508, 32'h900, 1, 0, 1, 1, 1);
        look(32'h508);
        chk("crReplace", tgtA, 32'h50C);
        exUpd(32'h508, 32'h900, 1, 0, 1, 0, 1);
        look(32'h508);
        chk("crPopEmpty", tgtA, 32'h900);

        // exValid=0 with toggling controls changes nothing
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exValid  = 1'b0;
            exPc     = 32'h304;
            exTarget = 32'h123;
            exTaken  = 1'b1;
            exBranch = i[0];
            exJump   = 1'b1;
            exCall   = 1'b1;
            exRet    = ~i[0];
        end
        idle();
        look(32'h304);
        chk("holdRas", tgtA, 32'h900);
        look(32'h100);
        chk("holdJmp", tgtA, 32'h200);

        // Alternating T/N at 0x40, 16 training updates starting with T
        for (int k = 0; k < 16; k++) exUpd(32'h40, 32'h800, (k % 2) == 0, 1, 0, 0, 0);
        look(32'h40);
        chk("gshT1Hit", 32'(hitG), 1);
        chk("gshT1Tgt", tgtG, 32'h800);
        chk("bimT1Hit", 32'(hitA), 0);
        exUpd(32'h40, 32'h800, 1, 1, 0, 0, 0);
        look(32'h40);
        chk("gshNHit", 32'(hitG), 0);
        chk("bimNHit", 32'(hitA), 1);
        exUpd(32'h40, 32'h800, 0, 1, 0, 0, 0);
        look(32'h40);
        chk("gshT2Hit", 32'(hitG), 1);
        chk("bimT2Hit", 32'(hitA), 0);

        // Reset with a simultaneous update
        exUpd(32'h40, 32'h800, 1, 1, 0, 0, 0);
        exUpd(32'h600, 32'h400, 1, 0, 1, 1, 0);
        exUpd(32'h700, 32'h400, 1, 0, 1, 1, 0);
        @(negedge clk);
        rst      = 1'b1;
        exValid  = 1'b1;
        exPc     = 32'h40;
        exTarget = 32'h800;
        exTaken  = 1'b1;
        exBranch = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle();
        look(32'h40);
        chk("rstUpdHitA", 32'(hitA), 0);
        chk("rstUpdTgtA", tgtA, 0);
        chk("rstUpdHitG", 32'(hitG), 0);
        look(32'h304);
        chk("rstRetHit", 32'(hitA), 0);
        exUpd(32'h304, 32'h900, 1, 0, 1, 0, 1);
        look(32'h304);
        chk("rstRasEmpty", tgtA, 32'h900);
        exUpd(32'h40, 32'h800, 1, 1, 0, 0, 0);
        look(32'h40);
        chk("rstCtrT", 32'(hitA), 1);
        exUpd(32'h40, 32'h800, 0, 1, 0, 0, 0);
        look(32'h40);
        chk("rstCtrN", 32'(hitA), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
